// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, fetch-strobe and fetch-state definitions
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [1:0] FETCH_NONE = 2'b00;
  localparam logic [1:0] FETCH_B1   = 2'b01;
  localparam logic [1:0] FETCH_B2   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR1 = 3'd1,
    S_LD1   = 3'd2,
    S_DEC   = 3'd3,
    S_ADDR2 = 3'd4,
    S_LD2   = 3'd5,
    S_EXEC  = 3'd6,
    S_HALT  = 3'd7
  } state_t;

  // Opcodes with bit 3 set carry a second byte, except HLT.
  function automatic logic is_two_byte(input logic [3:0] op);
    return op[3] && (op != OP_HLT);
  endfunction

endpackage

// File: rtl/ins_fetch_if.sv
// rtl/ins_fetch_if.sv - fetch sequencer bus towards ROM, instruction register and execute stage
interface ins_fetch_if #(
  parameter int PC_W = 8
);
  logic            run;
  logic [3:0]      ins;
  logic            exec_done;
  logic            jump;
  logic [PC_W-1:0] jump_addr;
  logic [PC_W-1:0] rom_addr;
  logic            rom_rd;
  logic [1:0]      fetch;
  logic [PC_W-1:0] pc;
  logic            exec;
  logic            halted;

  modport master (
    input  run, ins, exec_done, jump, jump_addr,
    output rom_addr, rom_rd, fetch, pc, exec, halted
  );

  modport slave (
    output run, ins, exec_done, jump, jump_addr,
    input  rom_addr, rom_rd, fetch, pc, exec, halted
  );
endinterface

// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - instruction fetch FSM and program counter
module ins_fetch
  import cpu_pkg::*;
#(
  parameter int PC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  ins_fetch_if.master bus
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      S_IDLE:  if (bus.run) state_d = S_ADDR1;
      S_ADDR1: state_d = S_LD1;
      S_LD1: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_DEC;
      end
      S_DEC: begin
        if (bus.ins == OP_HLT)        state_d = S_HALT;
        else if (is_two_byte(bus.ins)) state_d = S_ADDR2;
        else                           state_d = S_EXEC;
      end
      S_ADDR2: state_d = S_LD2;
      S_LD2: begin
        pc_d    = pc_q + 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          if (bus.jump) pc_d = bus.jump_addr;
          state_d = S_ADDR1;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state so no input reaches them combinationally.
  always_comb begin
    bus.rom_rd = 1'b0;
    bus.fetch  = FETCH_NONE;
    bus.exec   = 1'b0;
    bus.halted = 1'b0;
    case (state_q)
      S_ADDR1, S_ADDR2: bus.rom_rd = 1'b1;
      S_LD1:            bus.fetch  = FETCH_B1;
      S_LD2:            bus.fetch  = FETCH_B2;
      S_EXEC:           bus.exec   = 1'b1;
      S_HALT:           bus.halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.pc       = pc_q;
  assign bus.rom_addr = pc_q;

endmodule

// File: doc/ins_fetch.md
# ins_fetch

Instruction fetch sequencer for the 8-bit RISC CPU. It drives the program counter onto the ROM address bus and issues the 2-bit `fetch` strobes that load the instruction register. It reads the registered opcode back to decide between one-byte and two-byte instructions, then hands control to the execute stage. It sits between the ROM, the instruction register and the execute controller.

## Interface
Parameters:
- `PC_W`, 8: program counter and ROM address width.

Ports:
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: synchronous, active-low reset.
- `run`  in  1: start/resume request, sampled only in IDLE.
- `ins`  in  4: opcode currently held by the instruction register (byte 1 [7:4]).
- `exec_done`  in  1: execute stage finished the current instruction.
- `jump`  in  1: with `exec_done`, load `jump_addr` into PC.
- `jump_addr`  in  PC_W: branch target.
- `rom_addr`  out  PC_W: ROM address, equals `pc`.
- `rom_rd`  out  1: ROM read enable.
- `fetch`  out  2: 01 = load byte 1 into instruction register, 10 = load byte 2, 00 = hold.
- `pc`  out  PC_W: program counter.
- `exec`  out  1: high while waiting on the execute stage.
- `halted`  out  1: HLT executed.

## Operation
- States: IDLE, ADDR1, LD1, DEC, ADDR2, LD2, EXEC, HALT. Binary-encoded, registered state.
- The ROM is synchronous with 1-cycle read latency. The address is presented in an ADDR state and the data is valid on the bus in the following LD state.
- Opcode classes:
  - 4'hF = HLT.
  - `ins[3]==1` and not F: two-byte instruction (memory, immediate or jump).
  - Everything else, including 4'h0 NOP: one-byte instruction.
- State transitions:
  - IDLE: if `run` is high, go to ADDR1; otherwise stay.
  - ADDR1: `rom_rd`=1, go to LD1.
  - LD1: `fetch`=01, `pc`<=`pc`+1, go to DEC.
  - DEC: the instruction register now holds the new opcode. HLT goes to HALT, two-byte goes to ADDR2, else EXEC.
  - ADDR2: `rom_rd`=1, go to LD2.
  - LD2: `fetch`=10, `pc`<=`pc`+1, go to EXEC.
  - EXEC: `exec`=1. Stay until `exec_done`. On `exec_done`, `pc`<=`jump` ? `jump_addr` : `pc`, then go to ADDR1.
  - HALT: `halted`=1. Stay until reset; `run` is ignored.
- Output values outside the states listed above: `fetch`=00 and `rom_rd`=0.
- PC arithmetic is modulo 2^PC_W: 8'hFF+1 = 8'h00, with no flag.
- When `jump` and `exec_done` are both high, the jump takes priority. Only one PC update occurs per cycle.
- `jump` without `exec_done` is ignored. `jump_addr` is only sampled on the `exec_done` cycle.
- `exec_done` outside EXEC is ignored.

## Timing
- Reset (`rst`=0 at a clock edge) puts the block in IDLE with `pc`=0, `fetch`=00, `rom_rd`=0, `exec`=0, `halted`=0. This applies in every state, including mid-fetch; no partial fetch completes.
- All outputs are registered-state decodes, with no combinational path from inputs to outputs. `rom_addr` is a direct copy of `pc`.
- Counting `run` sampled in IDLE as cycle 0:
  - ADDR1 = cycle 1.
  - LD1 (`fetch`=01) = cycle 2.
  - DEC = cycle 3.
  - One-byte instruction: EXEC from cycle 4.
  - Two-byte instruction: ADDR2 = 4, LD2 = 5, EXEC from cycle 6.
- Minimum instruction period with `exec_done` high on the first EXEC cycle: 4 cycles for one-byte, 6 cycles for two-byte.
- The next ADDR1 follows the `exec_done` cycle directly.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants `OP_NOP`=4'h0 and `OP_HLT`=4'hF.
  - `fetch` encodings `FETCH_NONE`=2'b00, `FETCH_B1`=2'b01, `FETCH_B2`=2'b10.
  - state enum.
  - function `is_two_byte(op)`.
- No sub-module. A single FSM plus the PC register.

## Test plan
- Reset then `run`=1, ROM[0]=8'h25 (one-byte), `exec_done` on the first EXEC cycle:
  - `fetch`=01 at cycle 2 only.
  - `exec`=1 at cycle 4.
  - `pc`=1.
  - `rom_addr`=1 at cycle 5.
- Two-byte instruction, ROM[0]=8'h93, ROM[1]=8'h40:
  - `fetch`=01 at cycle 2 and 10 at cycle 5.
  - Instruction register ends with ins=9, ad1=3, ad2=8'h40.
  - `pc`=2 on entering EXEC.
- Jump: in EXEC assert `jump`=1, `jump_addr`=8'hC0 with `exec_done` -> next ADDR1 has `rom_addr`=8'hC0. Also assert `jump` without `exec_done` -> `pc` is unchanged.
- Wrap: `pc`=8'hFF fetching a one-byte opcode -> after LD1 `pc`=8'h00, with no stall or flag.
- HLT: ROM byte 8'hF0 -> HALT from cycle 4, `halted`=1, `fetch`=00. Toggling `run` has no effect; `rst`=0 returns to IDLE with `pc`=0.
- Reset mid-operation: `rst`=0 during LD2 and during EXEC with `exec_done`=1 -> next cycle IDLE, `pc`=0, `fetch`=00, with no PC increment or jump applied.
